sync_fifo_lvl: RTL and testbench
================================

Name: sync_fifo_lvl

Overview:
Parametrised synchronous FIFO. It succeeds the fixed 8x64 FIFO used in the UART datapath and generalises data width and depth.
Adds programmable almost-full and almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
Sits between the UART RX/TX shift engines and the bus-side register interface.

Parameters:
D_W, 8, data width in bits (>=1)
DEPTH, 64, number of entries; must be a power of two, >=4
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
data_in  in  D_W  write data
rd_en  in  1  read/pop request
data_out  out  D_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full and not accepted
underflow  out  1  sticky: a read was attempted while empty
err_clr  in  1  clears overflow and underflow

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data in that cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is a separate register. All flags are combinational compares on the registered count, so they change the cycle after the causing edge.
- Write accepted: wr_en & (!full | rd_accept). Stores data_in at wr_ptr, then increments wr_ptr.
- Read accepted (rd_accept): rd_en & !empty. Increments rd_ptr.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous rd_en and wr_en when full: both accepted, count stays DEPTH, no overflow.
- Simultaneous rd_en and wr_en when empty: write accepted, read rejected, underflow set, count becomes 1.
- Rejected write (wr_en & full & !rd_accept): data dropped, overflow <= 1.
- Rejected read (rd_en & empty): no pointer change, underflow <= 1.
- overflow/underflow clear on err_clr. If err_clr coincides with a new error event, the set wins.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on an accepted read. It is valid the cycle after rd_en and holds its value otherwise, including on rejected reads.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty, so the head word is visible with no rd_en needed. rd_en pops the word. data_out is don't-care while empty.
- Elaboration check: fatal if DEPTH is not a power of two, AF_THRESH > DEPTH, or AE_THRESH >= DEPTH.

Decomposition:
- Package fifo_pkg holds:
  - function clog2_depth
  - localparam-style defaults for D_W and DEPTH
  - typedef fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow} for register-map export
- Sub-module fifo_mem: simple dual-port array with one write port (clocked) and one asynchronous read port. It is shared by both FWFT modes.
- Control (pointers, count, flags, read register) lives in sync_fifo_lvl.

Test Plan:
1. FWFT=0: reset, then write 1..64 on consecutive cycles. Expect full=1 and count=64 after the 64th edge, almost_full=1 from count=60. A 65th write of 65 sets overflow=1 and count stays 64.
2. FWFT=0: from full, assert rd_en for 64 cycles. data_out shows 1..64, each one cycle after its rd_en. empty=1 at the end; one more rd_en sets underflow=1 and data_out holds 64.
3. FWFT=1: write 0xA5 once. data_out=0xA5 the cycle after empty drops, with no rd_en. Pop it: empty=1 and count=0.
4. Full with simultaneous rd_en/wr_en (write 0x77): count stays 64, no overflow. Read sequence continues in order, with 0x77 appearing after the 63 older words.
5. Wrap-around: push 40 and pop 40, then push 50 and pop 50. Data order is preserved across the pointer wrap, and almost_empty deasserts at count=5.
6. Reset mid-operation: with count=30 and overflow=1, pulse rst. Next cycle count=0, empty=1, overflow=0, data_out=0. err_clr asserted alone clears a set underflow.

Source files
------------

// File: rtl/sync_fifo_lvl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults, status record and sizing helper for the
//               parametrised level-reporting synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int C_DEF_D_W   = 8;
    localparam int C_DEF_DEPTH = 64;

    // Flag bundle exported towards the register map.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Number of address bits needed to index a memory of the given depth.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(depth)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_lvl_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port storage array, clocked write port and
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int D_W = 8,
    parameter int AW  = 6
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [D_W-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [D_W-1:0] rdata
);

    logic [D_W-1:0] mem_q [2**AW];

    // Store the write word at its slot on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_lvl
// Description : Parametrised synchronous FIFO with fill level, programmable
//               almost-full/almost-empty thresholds, sticky overflow and
//               underflow flags and optional first-word-fall-through read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int D_W       = C_DEF_D_W,
    parameter int DEPTH     = C_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [D_W-1:0]         data_in,
    input  logic                   rd_en,
    output logic [D_W-1:0]         data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);

    localparam int C_AW = clog2_depth(DEPTH);
    localparam int C_CW = C_AW + 1;

    localparam logic [C_CW-1:0] C_CNT_FULL = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_CNT_AF   = C_CW'(AF_THRESH);
    localparam logic [C_CW-1:0] C_CNT_AE   = C_CW'(AE_THRESH);

    // Reject illegal configurations at elaboration time.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $fatal(1, "sync_fifo_lvl: DEPTH must be a power of two and >= 4");
    end
    if (AF_THRESH > DEPTH) begin : g_chk_af
        $fatal(1, "sync_fifo_lvl: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_chk_ae
        $fatal(1, "sync_fifo_lvl: AE_THRESH must be below DEPTH");
    end

    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0] count_q,  count_d;
    logic            overflow_q,  overflow_d;
    logic            underflow_q, underflow_d;

    logic            rd_accept;
    logic            wr_accept;
    logic [D_W-1:0]  mem_rdata;
    fifo_status_t    status;

    // Flags are pure compares on the registered level.
    assign status.full         = (count_q == C_CNT_FULL);
    assign status.empty        = (count_q == '0);
    assign status.almost_full  = (count_q >= C_CNT_AF);
    assign status.almost_empty = (count_q <= C_CNT_AE);
    assign status.overflow     = overflow_q;
    assign status.underflow    = underflow_q;

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is also being read.
    assign rd_accept = rd_en & ~status.empty;
    assign wr_accept = wr_en & (~status.full | rd_accept);

    fifo_mem #(
        .D_W (D_W),
        .AW  (C_AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, level and sticky error flags; a new error
    // event takes priority over err_clr.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + C_AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + C_AW'(1);
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + C_CW'(1);
            2'b01:   count_d = count_q - C_CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_en & ~wr_accept) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        if (rd_en & status.empty) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so the
        // output is deterministic after reset.
        always_comb begin
            data_out = '0;
            if (!status.empty) begin
                data_out = mem_rdata;
            end
        end
    end else begin : g_reg_read
        logic [D_W-1:0] data_q, data_d;

        // Capture the head word only on an accepted pop, otherwise hold.
        always_comb begin
            data_d = data_q;
            if (rd_accept) begin
                data_d = mem_rdata;
            end
        end

        // Read data register.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign data_out = data_q;
    end

endmodule : sync_fifo_lvl
`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_lvl
// Description : Self-checking bench for sync_fifo_lvl, registered-read and
//               first-word-fall-through instances, queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_lvl;

    localparam int C_DW    = 8;
    localparam int C_DEPTH = 64;
    localparam int C_AF    = C_DEPTH - 4;
    localparam int C_AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Registered-read instance stimulus/response
    logic            wr_en = 1'b0;
    logic [C_DW-1:0] data_in = '0;
    logic            rd_en = 1'b0;
    logic            err_clr = 1'b0;
    logic [C_DW-1:0] data_out;
    logic            full, empty, almost_full, almost_empty, overflow, underflow;
    logic [6:0]      count;

    // FWFT instance stimulus/response
    logic            wr1 = 1'b0;
    logic [C_DW-1:0] din1 = '0;
    logic            rd1 = 1'b0;
    logic [C_DW-1:0] dout1;
    logic            full1, empty1, af1, ae1, ovf1, unf1;
    logic [6:0]      count1;

    sync_fifo_lvl #(
        .D_W(C_DW), .DEPTH(C_DEPTH), .AF_THRESH(C_AF), .AE_THRESH(C_AE), .FWFT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo_lvl #(
        .D_W(C_DW), .DEPTH(C_DEPTH), .AF_THRESH(C_AF), .AE_THRESH(C_AE), .FWFT(1)
    ) u_dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
        .data_out(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1), .err_clr(1'b0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [C_DW-1:0] sb[$];
    logic [C_DW-1:0] m_dout = '0;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = sb.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == C_DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= C_AF));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= C_AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
        chk("data_out",     32'(data_out),     32'(m_dout));
    endtask

    // One clock of stimulus on the registered-read instance, model updated
    // from the pre-edge fill level, state compared #1 after the edge.
    task automatic step(input logic wr, input logic [C_DW-1:0] din,
                        input logic rd, input logic clr);
        int  sz;
        bit  racc, wacc;
        sz   = sb.size();
        racc = rd && (sz != 0);
        wacc = wr && ((sz != C_DEPTH) || racc);
        wr_en = wr; data_in = din; rd_en = rd; err_clr = clr;
        if (racc) m_dout = sb.pop_front();
        if (wacc) sb.push_back(din);
        if (wr && !wacc)      m_ovf = 1'b1;
        else if (clr)         m_ovf = 1'b0;
        if (rd && (sz == 0))  m_unf = 1'b1;
        else if (clr)         m_unf = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        check_state();
    endtask

    initial begin
        logic [C_DW-1:0] v;

        // Reset state
        do_reset();
        chk("fwft_rst_empty", 32'(empty1), 32'd1);
        chk("fwft_rst_count", 32'(count1), 32'd0);

        // Fill 1..64, then a rejected 65th write
        for (int i = 1; i <= C_DEPTH; i++) step(1'b1, C_DW'(i), 1'b0, 1'b0);
        step(1'b1, 8'd65, 1'b0, 1'b0);
        chk("t1_ovf_set", 32'(overflow), 32'd1);

        // Drain all 64, then one rejected read
        for (int i = 1; i <= C_DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_unf_set", 32'(underflow), 32'd1);
        chk("t2_dout_hold", 32'(data_out), 32'd64);

        // Clear errors, refill, simultaneous read/write at full
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= C_DEPTH; i++) step(1'b1, C_DW'(i + 100), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4_full_rw_count", 32'(count), 32'd64);
        chk("t4_full_rw_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= C_DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_last_is_77", 32'(data_out), 32'h77);

        // Simultaneous read/write on empty: write taken, underflow raised
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);

        // Wrap-around with pseudo-random data
        for (int i = 0; i < 40; i++) step(1'b1, C_DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, C_DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b1, 1'b0);
        // Mixed traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom), C_DW'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));

        // Reset mid-operation with overflow pending and 30 words stored
        do_reset();
        for (int i = 0; i < C_DEPTH; i++) step(1'b1, C_DW'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_pre_count", 32'(count), 32'd30);
        do_reset();
        chk("t6_post_dout", 32'(data_out), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_errclr_unf", 32'(underflow), 32'd0);

        // FWFT instance: head visible with no pop, then pop empties it
        wr1 = 1'b1; din1 = 8'hA5;
        @(posedge clk); #1;
        wr1 = 1'b0;
        chk("fwft_empty_drop", 32'(empty1), 32'd0);
        chk("fwft_head", 32'(dout1), 32'hA5);
        @(posedge clk); #1;
        chk("fwft_head_hold", 32'(dout1), 32'hA5);
        wr1 = 1'b1; din1 = 8'h5A;
        @(posedge clk); #1;
        wr1 = 1'b0;
        rd1 = 1'b1;
        @(posedge clk); #1;
        rd1 = 1'b0;
        chk("fwft_next_head", 32'(dout1), 32'h5A);
        chk("fwft_count1", 32'(count1), 32'd1);
        v = 8'h5A;
        rd1 = 1'b1;
        @(posedge clk); #1;
        rd1 = 1'b0;
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_count", 32'(count1), 32'd0);
        chk("fwft_no_unf", 32'(unf1), 32'd0);
        if (v != 8'h5A) n_fail++;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo_lvl
`default_nettype wire
